div_issue_ctrl: RTL and testbench
=================================

Name: div_issue_ctrl

Overview:
Request/response sequencer that sits directly upstream and downstream of the unsigned restoring/non-restoring divider core.
- Upstream side: accepts a division request on a valid/ready interface.
- Special cases: detects divide-by-zero and signed overflow, and answers these without using the core.
- Normal path: converts signed operands to magnitudes, pulses the core's start, waits for its done under a watchdog, sign-corrects the quotient and remainder, and presents the result on a valid/ready response interface.

Parameters:
BIT_SIZE, 16, operand/result width; must match the divider core.
TIMEOUT_CYCLES, 2*BIT_SIZE+4, maximum WAIT cycles before declaring the core hung.

Ports:
clk  in  1  single clock, rising edge
reset  in  1  synchronous, active-high
req_valid  in  1  request present
req_ready  out  1  high only in IDLE
req_dividend  in  BIT_SIZE  dividend
req_divisor  in  BIT_SIZE  divisor
req_signed  in  1  1 = two's-complement operation, 0 = unsigned
div_start  out  1  one-cycle start pulse to the core
div_dividend  out  BIT_SIZE  magnitude of the dividend to the core
div_divisor  out  BIT_SIZE+1  zero-extended magnitude of the divisor to the core
div_done  in  1  core finished
div_quotient  in  BIT_SIZE  core quotient (unsigned)
div_remainder  in  BIT_SIZE  core remainder (unsigned)
rsp_valid  out  1  response present
rsp_ready  in  1  consumer accepts
rsp_quotient  out  BIT_SIZE  final quotient
rsp_remainder  out  BIT_SIZE  final remainder
rsp_div_by_zero  out  1  divisor was zero
rsp_overflow  out  1  signed MIN / -1
rsp_timeout  out  1  core never asserted done

Behaviour:
Clock and reset:
- One clock, clk.
- Reset is synchronous and active-high on reset.
- While reset is high: state=IDLE, and every output register is 0 (div_start, rsp_valid, all rsp_* fields, div_dividend, div_divisor).
- req_ready=1 in the first cycle after reset deasserts.
- Reset mid-operation aborts at once; the next div_done is ignored because the block is not in WAIT.

States: IDLE, LAUNCH, WAIT, RESP.

IDLE:
- req_ready=1.
- On req_valid&&req_ready, register the operands, req_signed, neg_q = signed && (sign(dvd) XOR sign(dvs)), and neg_r = signed && sign(dvd).
- Divisor == 0: go to RESP with quotient=all-ones, remainder=dividend (raw), rsp_div_by_zero=1.
- Signed, dividend == 1 followed by zeros (MIN), divisor == all-ones (-1): go to RESP with quotient=MIN, remainder=0, rsp_overflow=1.
- Otherwise: go to LAUNCH with div_dividend and div_divisor loaded with the magnitudes. Magnitudes are the raw values when unsigned.

LAUNCH:
- div_start=1 for exactly this cycle.
- div_dividend and div_divisor stay stable from LAUNCH until leaving WAIT.
- Go to WAIT and clear the watchdog counter.

WAIT:
- div_start=0; the counter increments each cycle.
- On div_done=1: capture the results, negate the quotient if neg_q and the remainder if neg_r (two's complement, modulo 2^BIT_SIZE), then go to RESP.
- Else if the counter reaches TIMEOUT_CYCLES-1: go to RESP with quotient=0, remainder=0, rsp_timeout=1.
- div_done takes priority over timeout when both occur in the same cycle.
- div_done is ignored in every state other than WAIT.

RESP:
- rsp_valid=1 and all rsp_* fields are held stable until rsp_ready.
- On rsp_valid&&rsp_ready: clear rsp_valid and the flags, then go to IDLE.
- Back-to-back requests are not accepted: req_ready stays 0 until the cycle after the handshake.

Latency:
- Special case: response valid 1 cycle after acceptance.
- Normal: response valid 1 cycle after the cycle in which div_done is sampled.
- At most one flag is set per response.

Decomposition:
- Package div_pkg:
  - state enum type div_state_t (IDLE, LAUNCH, WAIT, RESP)
  - default BIT_SIZE constant
  - function for the default timeout value
  - a MIN-value helper function
- Sub-module div_sign_fix (combinational, parameterised by BIT_SIZE): conditional two's-complement negate of a value given a negate flag. Instantiate it twice for operand magnitudes (divisor output zero-extended to BIT_SIZE+1 bits) and twice for result correction.

Test Plan:
BIT_SIZE=16; the bench's behavioural core asserts div_done 17 cycles after div_start unless stated otherwise.
1. Unsigned 100/7 -> div_dividend=100, div_divisor=7, single div_start pulse; rsp q=14, r=2, all flags 0.
2. Signed -100/7 (0xFF9C/0x0007) -> core sees 100/7; rsp q=0xFFF2, r=0xFFFE. Signed 100/-7 -> q=0xFFF2, r=0x0002.
3. 1234/0, unsigned and signed -> div_start never asserts; rsp q=0xFFFF, r=1234, rsp_div_by_zero=1, rsp_valid 1 cycle after acceptance.
4. Signed 0x8000/0xFFFF -> no div_start; q=0x8000, r=0, rsp_overflow=1. Same operands unsigned -> normal path, q=0, r=0x8000.
5. Hold rsp_ready=0 for 5 cycles after rsp_valid -> outputs stable and req_ready=0 throughout; the handshake returns to IDLE with req_ready=1 the next cycle.
6. Core never asserts done -> rsp_timeout=1, q=r=0 after TIMEOUT_CYCLES (36) WAIT cycles. Separately, assert reset during WAIT -> all outputs 0 and IDLE; a late div_done is ignored, and a new 100/7 completes correctly.

Source files
------------

// File: rtl/div_pkg.sv
// Shared types and constants for the divider issue controller.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        WAIT   = 2'd2,
        RESP   = 2'd3
    } div_state_t;

    localparam int DIV_BIT_SIZE = 16;

    function automatic int div_timeout_default(input int bit_size);
        return 2 * bit_size + 4;
    endfunction

    // Most negative two's-complement value for the given width (1 followed by zeros).
    function automatic logic [63:0] div_min_value(input int bit_size);
        return 64'd1 << (bit_size - 1);
    endfunction

endpackage

// File: rtl/div_sign_fix.sv
// Conditional two's-complement negate; used for operand magnitudes and result sign correction.
module div_sign_fix
    import div_pkg::*;
#(
    parameter int BIT_SIZE = DIV_BIT_SIZE
) (
    input  logic [BIT_SIZE-1:0] value,
    input  logic                negate,
    output logic [BIT_SIZE-1:0] result
);

    assign result = negate ? (~value + {{(BIT_SIZE-1){1'b0}}, 1'b1}) : value;

endmodule

// File: rtl/div_issue_ctrl.sv
// Request/response sequencer around an unsigned divider core: special-case handling,
// sign conversion, start pulse, watchdog and result sign correction.
//
// state  | meaning
// IDLE   | ready for a request; special cases answered directly
// LAUNCH | div_start pulse, watchdog loaded
// WAIT   | waiting for div_done or watchdog expiry
// RESP   | response held until rsp_ready
module div_issue_ctrl
    import div_pkg::*;
#(
    parameter int BIT_SIZE       = DIV_BIT_SIZE,
    parameter int TIMEOUT_CYCLES = div_timeout_default(BIT_SIZE)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [BIT_SIZE-1:0] req_dividend,
    input  logic [BIT_SIZE-1:0] req_divisor,
    input  logic                req_signed,
    output logic                div_start,
    output logic [BIT_SIZE-1:0] div_dividend,
    output logic [BIT_SIZE:0]   div_divisor,
    input  logic                div_done,
    input  logic [BIT_SIZE-1:0] div_quotient,
    input  logic [BIT_SIZE-1:0] div_remainder,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [BIT_SIZE-1:0] rsp_quotient,
    output logic [BIT_SIZE-1:0] rsp_remainder,
    output logic                rsp_div_by_zero,
    output logic                rsp_overflow,
    output logic                rsp_timeout
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0]    CNT_LOAD = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [BIT_SIZE-1:0] MIN_VAL  = BIT_SIZE'(div_min_value(BIT_SIZE));

    div_state_t          state, state_nxt;
    logic [CNT_W-1:0]    wd_cnt, wd_cnt_nxt;
    logic                neg_q, neg_q_nxt, neg_r, neg_r_nxt;
    logic [BIT_SIZE-1:0] div_dividend_nxt;
    logic [BIT_SIZE:0]   div_divisor_nxt;
    logic [BIT_SIZE-1:0] quotient_nxt, remainder_nxt;
    logic                dbz_nxt, ovf_nxt, to_nxt;
    logic [BIT_SIZE-1:0] dvd_mag, dvs_mag, q_fix, r_fix;

    div_sign_fix #(.BIT_SIZE(BIT_SIZE)) u_dvd_mag (
        .value(req_dividend), .negate(req_signed & req_dividend[BIT_SIZE-1]), .result(dvd_mag));
    div_sign_fix #(.BIT_SIZE(BIT_SIZE)) u_dvs_mag (
        .value(req_divisor), .negate(req_signed & req_divisor[BIT_SIZE-1]), .result(dvs_mag));
    div_sign_fix #(.BIT_SIZE(BIT_SIZE)) u_q_fix (
        .value(div_quotient), .negate(neg_q), .result(q_fix));
    div_sign_fix #(.BIT_SIZE(BIT_SIZE)) u_r_fix (
        .value(div_remainder), .negate(neg_r), .result(r_fix));

    assign req_ready = (state == IDLE);
    assign div_start = (state == LAUNCH);
    assign rsp_valid = (state == RESP);

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= IDLE;
            wd_cnt          <= '0;
            neg_q           <= 1'b0;
            neg_r           <= 1'b0;
            div_dividend    <= '0;
            div_divisor     <= '0;
            rsp_quotient    <= '0;
            rsp_remainder   <= '0;
            rsp_div_by_zero <= 1'b0;
            rsp_overflow    <= 1'b0;
            rsp_timeout     <= 1'b0;
        end else begin
            state           <= state_nxt;
            wd_cnt          <= wd_cnt_nxt;
            neg_q           <= neg_q_nxt;
            neg_r           <= neg_r_nxt;
            div_dividend    <= div_dividend_nxt;
            div_divisor     <= div_divisor_nxt;
            rsp_quotient    <= quotient_nxt;
            rsp_remainder   <= remainder_nxt;
            rsp_div_by_zero <= dbz_nxt;
            rsp_overflow    <= ovf_nxt;
            rsp_timeout     <= to_nxt;
        end
    end

    always_comb begin
        state_nxt        = state;
        wd_cnt_nxt       = wd_cnt;
        neg_q_nxt        = neg_q;
        neg_r_nxt        = neg_r;
        div_dividend_nxt = div_dividend;
        div_divisor_nxt  = div_divisor;
        quotient_nxt     = rsp_quotient;
        remainder_nxt    = rsp_remainder;
        dbz_nxt          = rsp_div_by_zero;
        ovf_nxt          = rsp_overflow;
        to_nxt           = rsp_timeout;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    neg_q_nxt = req_signed & (req_dividend[BIT_SIZE-1] ^ req_divisor[BIT_SIZE-1]);
                    neg_r_nxt = req_signed & req_dividend[BIT_SIZE-1];
                    if (req_divisor == '0) begin
                        quotient_nxt  = '1;
                        remainder_nxt = req_dividend;
                        dbz_nxt       = 1'b1;
                        state_nxt     = RESP;
                    end else if (req_signed && req_dividend == MIN_VAL && req_divisor == '1) begin
                        quotient_nxt  = MIN_VAL;
                        remainder_nxt = '0;
                        ovf_nxt       = 1'b1;
                        state_nxt     = RESP;
                    end else begin
                        div_dividend_nxt = dvd_mag;
                        div_divisor_nxt  = {1'b0, dvs_mag};
                        state_nxt        = LAUNCH;
                    end
                end
            end
            LAUNCH: begin
                wd_cnt_nxt = CNT_LOAD;
                state_nxt  = WAIT;
            end
            WAIT: begin
                // done wins over an expiring watchdog in the same cycle
                if (div_done) begin
                    quotient_nxt  = q_fix;
                    remainder_nxt = r_fix;
                    state_nxt     = RESP;
                end else if (wd_cnt == '0) begin
                    quotient_nxt  = '0;
                    remainder_nxt = '0;
                    to_nxt        = 1'b1;
                    state_nxt     = RESP;
                end else begin
                    wd_cnt_nxt = wd_cnt - 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    dbz_nxt   = 1'b0;
                    ovf_nxt   = 1'b0;
                    to_nxt    = 1'b0;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Directed vector bench for div_issue_ctrl with a fixed-latency behavioural divider core.
module tb_div_issue_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [15:0] req_dividend = '0;
    logic [15:0] req_divisor = '0;
    logic        req_signed = 1'b0;
    logic        div_start;
    logic [15:0] div_dividend;
    logic [16:0] div_divisor;
    logic        div_done = 1'b0;
    logic [15:0] div_quotient = '0;
    logic [15:0] div_remainder = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [15:0] rsp_quotient;
    logic [15:0] rsp_remainder;
    logic        rsp_div_by_zero;
    logic        rsp_overflow;
    logic        rsp_timeout;

    int n_checks = 0;
    int n_errors = 0;

    div_issue_ctrl #(.BIT_SIZE(16)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_dividend(req_dividend), .req_divisor(req_divisor), .req_signed(req_signed),
        .div_start(div_start), .div_dividend(div_dividend), .div_divisor(div_divisor),
        .div_done(div_done), .div_quotient(div_quotient), .div_remainder(div_remainder),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_quotient(rsp_quotient), .rsp_remainder(rsp_remainder),
        .rsp_div_by_zero(rsp_div_by_zero), .rsp_overflow(rsp_overflow), .rsp_timeout(rsp_timeout)
    );

    always #5 clk = ~clk;

    // behavioural core: done pulses 17 cycles after the start is sampled
    logic        core_en = 1'b1;
    int          core_cnt = 0;
    logic [15:0] core_q = '0;
    logic [15:0] core_r = '0;
    int          n_start = 0;
    logic [15:0] seen_dvd = '0;
    logic [16:0] seen_dvs = '0;

    always @(posedge clk) begin
        div_done <= 1'b0;
        if (core_cnt != 0) begin
            core_cnt <= core_cnt - 1;
            if (core_cnt == 1) begin
                div_done      <= 1'b1;
                div_quotient  <= core_q;
                div_remainder <= core_r;
            end
        end
        if (div_start && core_en) begin
            core_cnt <= 17;
            core_q   <= div_dividend / div_divisor[15:0];
            core_r   <= div_dividend % div_divisor[15:0];
        end
    end

    always @(posedge clk) begin
        if (div_start) begin
            n_start  <= n_start + 1;
            seen_dvd <= div_dividend;
            seen_dvs <= div_divisor;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [15:0] dvd;
        logic [15:0] dvs;
        logic        sgn;
        logic        core;
        logic [15:0] cdvd;
        logic [16:0] cdvs;
        logic [15:0] q;
        logic [15:0] r;
        logic        dbz;
        logic        ovf;
    } vec_t;

    vec_t vecs[10];

    task automatic send_req(input logic [15:0] dvd, input logic [15:0] dvs, input logic sgn);
        int n;
        @(negedge clk);
        req_dividend = dvd;
        req_divisor  = dvs;
        req_signed   = sgn;
        req_valid    = 1'b1;
        n = 0;
        while (!req_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        check("req_ready_before_accept", {31'd0, req_ready}, 32'd1);
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    // returns number of negedges waited after the acceptance edge
    task automatic wait_rsp(output int lat);
        lat = 0;
        @(negedge clk);
        while (!rsp_valid && lat < 100) begin
            lat++;
            @(negedge clk);
        end
    endtask

    task automatic handshake(input int hold);
        logic [15:0] q0, r0;
        logic [2:0]  f0;
        int bad;
        q0 = rsp_quotient;
        r0 = rsp_remainder;
        f0 = {rsp_div_by_zero, rsp_overflow, rsp_timeout};
        bad = 0;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (!rsp_valid || req_ready || rsp_quotient !== q0 || rsp_remainder !== r0 ||
                {rsp_div_by_zero, rsp_overflow, rsp_timeout} !== f0)
                bad++;
        end
        check("rsp_hold_stable", bad, 0);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("post_hs_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("post_hs_req_ready", {31'd0, req_ready}, 32'd1);
        check("post_hs_flags", {29'd0, rsp_div_by_zero, rsp_overflow, rsp_timeout}, 32'd0);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int base, lat;
        string tag;
        tag = $sformatf("v%0d", idx);
        base = n_start;
        send_req(v.dvd, v.dvs, v.sgn);
        wait_rsp(lat);
        check({tag, "_latency"}, lat, v.core ? 32'd19 : 32'd0);
        check({tag, "_starts"}, n_start - base, v.core ? 32'd1 : 32'd0);
        if (v.core) begin
            check({tag, "_core_dvd"}, {16'd0, seen_dvd}, {16'd0, v.cdvd});
            check({tag, "_core_dvs"}, {15'd0, seen_dvs}, {15'd0, v.cdvs});
        end
        check({tag, "_q"}, {16'd0, rsp_quotient}, {16'd0, v.q});
        check({tag, "_r"}, {16'd0, rsp_remainder}, {16'd0, v.r});
        check({tag, "_flags"}, {29'd0, rsp_div_by_zero, rsp_overflow, rsp_timeout},
              {29'd0, v.dbz, v.ovf, 1'b0});
        handshake(2);
    endtask

    initial begin
        int lat, bad, base;

        vecs[0] = '{16'd100,  16'd7,     1'b0, 1'b1, 16'd100,  17'd7,      16'd14,    16'd2,     1'b0, 1'b0};
        vecs[1] = '{16'hFF9C, 16'h0007,  1'b1, 1'b1, 16'd100,  17'd7,      16'hFFF2,  16'hFFFE,  1'b0, 1'b0};
        vecs[2] = '{16'h0064, 16'hFFF9,  1'b1, 1'b1, 16'd100,  17'd7,      16'hFFF2,  16'h0002,  1'b0, 1'b0};
        vecs[3] = '{16'd1234, 16'd0,     1'b0, 1'b0, 16'd0,    17'd0,      16'hFFFF,  16'd1234,  1'b1, 1'b0};
        vecs[4] = '{16'd1234, 16'd0,     1'b1, 1'b0, 16'd0,    17'd0,      16'hFFFF,  16'd1234,  1'b1, 1'b0};
        vecs[5] = '{16'h8000, 16'hFFFF,  1'b1, 1'b0, 16'd0,    17'd0,      16'h8000,  16'h0000,  1'b0, 1'b1};
        vecs[6] = '{16'h8000, 16'hFFFF,  1'b0, 1'b1, 16'h8000, 17'h0FFFF,  16'h0000,  16'h8000,  1'b0, 1'b0};
        vecs[7] = '{16'hFF9C, 16'hFFF9,  1'b1, 1'b1, 16'd100,  17'd7,      16'h000E,  16'hFFFE,  1'b0, 1'b0};
        vecs[8] = '{16'hFF9C, 16'h0007,  1'b0, 1'b1, 16'hFF9C, 17'd7,      16'h2484,  16'h0000,  1'b0, 1'b0};
        vecs[9] = '{16'h8000, 16'h0002,  1'b1, 1'b1, 16'h8000, 17'd2,      16'hC000,  16'h0000,  1'b0, 1'b0};

        // reset state
        repeat (3) @(negedge clk);
        check("reset_outputs", {rsp_valid, div_start, rsp_div_by_zero, rsp_overflow, rsp_timeout,
              rsp_quotient, rsp_remainder != 16'd0, div_dividend != 16'd0, div_divisor != 17'd0}, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("req_ready_after_reset", {31'd0, req_ready}, 32'd1);

        for (int i = 0; i < 10; i++) run_vec(vecs[i], i);

        // long backpressure on the response
        send_req(16'd100, 16'd7, 1'b0);
        wait_rsp(lat);
        check("bp_q", {16'd0, rsp_quotient}, 32'd14);
        handshake(5);

        // watchdog: core never answers
        core_en = 1'b0;
        base = n_start;
        send_req(16'd100, 16'd7, 1'b0);
        wait_rsp(lat);
        check("to_latency", lat, 32'd37);
        check("to_flags", {29'd0, rsp_div_by_zero, rsp_overflow, rsp_timeout}, 32'd1);
        check("to_qr", {rsp_quotient, rsp_remainder}, 32'd0);
        check("to_starts", n_start - base, 32'd1);
        handshake(1);
        core_en = 1'b1;

        // reset while waiting for the core; its later done must be ignored
        send_req(16'd100, 16'd7, 1'b0);
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("midreset_outputs", {rsp_valid, div_start, rsp_div_by_zero, rsp_overflow, rsp_timeout,
              rsp_quotient, rsp_remainder != 16'd0, div_dividend != 16'd0, div_divisor != 17'd0}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        bad = 0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (rsp_valid || div_start || !req_ready) bad++;
        end
        check("late_done_ignored", bad, 0);
        run_vec(vecs[0], 10);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: bench did not complete, expected finish before 200000");
        $fatal(1, "bench timeout");
    end

endmodule
